axil_io_bridge: RTL and testbench
=================================

# axil_io_bridge

Parametrised bridge from the soft CPU's single-outstanding IO bus to a full AXI4-Lite master port. It sits between the CPU core's IO port and the peripheral interconnect. Compared with the first-generation bridge it adds independent AW/W channels, full B/R handshakes, response-error reporting, registered read data, width parameters and an optional bus-timeout watchdog.

## Interface
- ADDR_W, 32, address width of the IO bus and AXI address channels
- DATA_W, 32, data width; must be 32 or 64; strobe width is DATA_W/8
- TIMEOUT, 255, watchdog limit in cycles, range 1..65535; used only with the watchdog compiled in
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- io_addr_strobe  in  1  one-cycle transaction-start pulse
- io_read_strobe / io_write_strobe  in  1  qualify io_addr_strobe; exactly one is high with it
- io_addr  in  ADDR_W  byte address
- io_byte_enable  in  DATA_W/8  write byte lanes
- io_write_data  in  DATA_W  write data
- io_read_data  out  DATA_W  read data; valid while io_ready is high
- io_ready  out  1  one-cycle completion pulse
- io_error  out  1  valid with io_ready: 1 = SLVERR/DECERR/timeout
- awvalid, awready, awaddr[ADDR_W], awprot[3]  AW channel (out, in, out, out)
- wvalid, wready, wdata[DATA_W], wstrb[DATA_W/8]  W channel (out, in, out, out)
- bvalid, bready, bresp[2]  B channel (in, out, in)
- arvalid, arready, araddr[ADDR_W], arprot[3]  AR channel (out, in, out, out)
- rvalid, rready, rdata[DATA_W], rresp[2]  R channel (in, out, in, in)

## Operation
- FSM states: IDLE, WRITE, WRESP, RADDR, RDATA.
- IDLE, with io_addr_strobe and io_write_strobe:
  - latch addr, data and strobes;
  - set awvalid = wvalid = 1;
  - go to WRITE.
- IDLE, with io_addr_strobe and io_read_strobe:
  - latch addr;
  - set arvalid = 1;
  - go to RADDR.
- WRITE:
  - awvalid clears on awready; wvalid clears on wready. The channels are independent, and either may be accepted first or both in the same cycle.
  - When both have been accepted, go to WRESP. If both are accepted in the same cycle, go to WRESP on the next cycle.
- WRESP: bready = 1. On bvalid:
  - pulse io_ready;
  - io_error = (bresp != 2'b00);
  - return to IDLE.
- RADDR: arvalid clears on arready, then go to RDATA.
- RDATA: rready = 1. On rvalid:
  - register rdata into io_read_data;
  - pulse io_ready;
  - io_error = (rresp != 2'b00);
  - return to IDLE.
- A strobe outside IDLE is ignored. The CPU never issues one, and it does not disturb the transaction in flight.
- awaddr and araddr both output the latched address. awprot and arprot are constant 3'b000.
- bready and rready are also 1 in IDLE. This drains stray or late responses, which are discarded with no io_ready.
- io_read_data holds its value until the next read completes. Write completions leave it unchanged.
- Reset values:
  - all valids = 0;
  - io_ready = 0, io_error = 0;
  - io_read_data = 0, awaddr/araddr = 0, wdata = 0, wstrb = 0;
  - state = IDLE.
- Reset mid-transaction returns to IDLE immediately, deasserting every valid. Interconnect reset is shared, so this is permitted.

## Timing
- All outputs are registered.
- The strobe in cycle 0 makes awvalid/wvalid (or arvalid) high in cycle 1.
- A valid/ready handshake in cycle n drops the valid in cycle n+1.
- bvalid or rvalid in cycle n gives io_ready and io_error in cycle n+1.
- Zero-wait write slave (ready tied 1, bvalid one cycle after acceptance):
  - strobe in cycle 0;
  - AW/W accepted in cycle 1;
  - WRESP in cycle 2, bvalid in cycle 2;
  - io_ready in cycle 3.
- Zero-wait read: arready in cycle 1, rvalid in cycle 2, io_ready in cycle 3.
- A new strobe is accepted in the same cycle io_ready is high, because the state is already IDLE.

## Configuration
- AXIL_IO_BRIDGE_TIMEOUT_EN defined: watchdog is compiled in.
  - A 16-bit counter clears in IDLE and increments every cycle in any other state.
  - On reaching TIMEOUT, the transaction aborts in that cycle: all valids clear, the FSM goes to IDLE, io_ready = 1 and io_error = 1 on the next cycle, and io_read_data is unchanged.
  - If a response arrives in the same cycle as the timeout, the response wins.
- Undefined: no counter. A silent slave hangs the CPU indefinitely.

## Test plan
- Write to 0x0000_1000, data 0xDEADBEEF, byte enable 0xF, zero-wait slave, bresp = 0 -> awaddr 0x1000, wdata 0xDEADBEEF and wstrb 0xF seen in cycle 1; io_ready in cycle 3 with io_error = 0.
- Write with awready delayed 4 cycles and wready immediate -> wvalid drops in cycle 2, awvalid drops after its handshake; exactly one io_ready after bvalid.
- Read 0x0000_2004, rdata 0x12345678, rresp = 2'b10 -> io_read_data = 0x12345678 and io_error = 1 with the io_ready pulse; io_read_data holds through the following write.
- Back-to-back: a read strobe in the same cycle as a write's io_ready -> arvalid is high in the next cycle, with no lost transaction.
- With the watchdog compiled in and TIMEOUT = 8, a read to a slave that never asserts arready -> arvalid drops, and io_ready with io_error = 1 comes exactly 9 cycles after the strobe; a stray rvalid afterwards produces no io_ready.
- rst_n low for 1 cycle while in WRESP -> all valids = 0 and state IDLE on the next edge; no io_ready is generated.

Source files
------------

// File: rtl/axil_io_bridge.sv
// -----------------------------------------------------------------------------
// axil_io_bridge
//
// Bridges the soft CPU's single-outstanding IO bus onto an AXI4-Lite master
// port. Only one transaction is in flight at a time. AW and W are issued
// together and retire independently. B and R are fully handshaken. Read data
// is registered and held until the next read completes. Any non-OKAY response
// is reported on io_error.
//
// Optional feature, selected at compile time:
//   AXIL_IO_BRIDGE_TIMEOUT_EN - when defined, a 16-bit bus watchdog is
//                               compiled in. A transaction that is still
//                               open after TIMEOUT cycles is aborted and
//                               completes with io_error = 1.
//
// Parameters:
//   ADDR_W   address width of the IO bus and the AXI address channels
//   DATA_W   data width, 32 or 64; strobe width is DATA_W/8
//   TIMEOUT  watchdog limit in cycles, 1..65535 (watchdog builds only)
//
// Ports:
//   clk, rst_n                   clock (rising edge), synchronous active-low reset
//   io_addr_strobe               one-cycle transaction-start pulse
//   io_read_strobe               qualifies io_addr_strobe as a read
//   io_write_strobe              qualifies io_addr_strobe as a write
//   io_addr                      byte address
//   io_byte_enable               write byte lanes
//   io_write_data                write data
//   io_read_data                 read data, valid while io_ready is high
//   io_ready                     one-cycle completion pulse
//   io_error                     qualified by io_ready; SLVERR/DECERR/timeout
//   aw*/w*/b*/ar*/r*             AXI4-Lite master channels
// -----------------------------------------------------------------------------
module axil_io_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  io_addr_strobe,
    input  logic                  io_read_strobe,
    input  logic                  io_write_strobe,
    input  logic [ADDR_W-1:0]     io_addr,
    input  logic [DATA_W/8-1:0]   io_byte_enable,
    input  logic [DATA_W-1:0]     io_write_data,
    output logic [DATA_W-1:0]     io_read_data,
    output logic                  io_ready,
    output logic                  io_error,

    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awprot,

    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,

    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,

    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arprot,

    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp
);

    localparam int STRB_W = DATA_W / 8;

    // Elaboration-time parameter sanity checks.
    if (!((DATA_W == 32) || (DATA_W == 64))) begin : g_bad_data_w
        $error("axil_io_bridge: DATA_W must be 32 or 64");
    end
    if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
        $error("axil_io_bridge: TIMEOUT must be in 1..65535");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } state_t;

    // Registered state and outputs
    state_t              state_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [STRB_W-1:0]   wstrb_r;
    logic                awvalid_r;
    logic                wvalid_r;
    logic                arvalid_r;
    logic                bready_r;
    logic                rready_r;
    logic                io_ready_r;
    logic                io_error_r;
    logic [DATA_W-1:0]   io_read_data_r;

    // Next-state / control decode
    state_t              state_s;
    logic                awvalid_s;
    logic                wvalid_s;
    logic                arvalid_s;
    logic                bready_s;
    logic                rready_s;
    logic                io_ready_s;
    logic                io_error_s;
    logic                load_addr_s;
    logic                load_wr_s;
    logic                capture_rdata_s;
    logic                aw_hs_s;
    logic                w_hs_s;
    logic                timeout_s;

`ifdef AXIL_IO_BRIDGE_TIMEOUT_EN
    localparam logic [16:0] TIMEOUT_LIM = 17'(TIMEOUT);

    logic [15:0] wdog_cnt_r;

    // Watchdog counter: cleared while idle, counts every busy cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_cnt_r <= 16'd0;
        end else if (state_r == IDLE) begin
            wdog_cnt_r <= 16'd0;
        end else begin
            wdog_cnt_r <= wdog_cnt_r + 16'd1;
        end
    end

    // The limit is reached in the cycle whose increment would land on
    // TIMEOUT. This makes the abort pulse appear TIMEOUT+1 cycles after
    // the strobe.
    assign timeout_s = (state_r != IDLE) &&
                       (({1'b0, wdog_cnt_r} + 17'd1) == TIMEOUT_LIM);
`else
    assign timeout_s = 1'b0;
`endif

    assign aw_hs_s = awvalid_r && awready;
    assign w_hs_s  = wvalid_r  && wready;

    // Next-state, handshake and completion decode.
    always_comb begin
        state_s         = state_r;
        awvalid_s       = awvalid_r;
        wvalid_s        = wvalid_r;
        arvalid_s       = arvalid_r;
        io_ready_s      = 1'b0;
        io_error_s      = 1'b0;
        load_addr_s     = 1'b0;
        load_wr_s       = 1'b0;
        capture_rdata_s = 1'b0;

        case (state_r)
            IDLE: begin
                if (io_addr_strobe && io_write_strobe) begin
                    load_addr_s = 1'b1;
                    load_wr_s   = 1'b1;
                    awvalid_s   = 1'b1;
                    wvalid_s    = 1'b1;
                    state_s     = WRITE;
                end else if (io_addr_strobe && io_read_strobe) begin
                    load_addr_s = 1'b1;
                    arvalid_s   = 1'b1;
                    state_s     = RADDR;
                end else begin
                    // Stray B/R beats are drained here and produce no completion.
                    state_s = IDLE;
                end
            end

            WRITE: begin
                if (aw_hs_s) begin
                    awvalid_s = 1'b0;
                end else begin
                    awvalid_s = awvalid_r;
                end
                if (w_hs_s) begin
                    wvalid_s = 1'b0;
                end else begin
                    wvalid_s = wvalid_r;
                end
                // A channel that is no longer valid has already been accepted.
                if ((aw_hs_s || !awvalid_r) && (w_hs_s || !wvalid_r)) begin
                    state_s = WRESP;
                end else begin
                    state_s = WRITE;
                end
            end

            WRESP: begin
                if (bvalid) begin
                    io_ready_s = 1'b1;
                    io_error_s = (bresp != 2'b00);
                    state_s    = IDLE;
                end else begin
                    state_s = WRESP;
                end
            end

            RADDR: begin
                if (arvalid_r && arready) begin
                    arvalid_s = 1'b0;
                    state_s   = RDATA;
                end else begin
                    state_s = RADDR;
                end
            end

            RDATA: begin
                if (rvalid) begin
                    capture_rdata_s = 1'b1;
                    io_ready_s      = 1'b1;
                    io_error_s      = (rresp != 2'b00);
                    state_s         = IDLE;
                end else begin
                    state_s = RDATA;
                end
            end

            default: begin
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
                arvalid_s = 1'b0;
                state_s   = IDLE;
            end
        endcase

        // Watchdog abort. A response arriving in the same cycle has already
        // raised io_ready_s and takes priority.
        if (timeout_s && !io_ready_s) begin
            awvalid_s       = 1'b0;
            wvalid_s        = 1'b0;
            arvalid_s       = 1'b0;
            capture_rdata_s = 1'b0;
            io_ready_s      = 1'b1;
            io_error_s      = 1'b1;
            state_s         = IDLE;
        end else begin
            io_ready_s = io_ready_s;
        end

        // Response readies follow the state being entered so they stay registered.
        bready_s = (state_s == IDLE) || (state_s == WRESP);
        rready_s = (state_s == IDLE) || (state_s == RDATA);
    end

    // FSM state, channel valids, response readies and completion flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            awvalid_r  <= 1'b0;
            wvalid_r   <= 1'b0;
            arvalid_r  <= 1'b0;
            bready_r   <= 1'b1;
            rready_r   <= 1'b1;
            io_ready_r <= 1'b0;
            io_error_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            awvalid_r  <= awvalid_s;
            wvalid_r   <= wvalid_s;
            arvalid_r  <= arvalid_s;
            bready_r   <= bready_s;
            rready_r   <= rready_s;
            io_ready_r <= io_ready_s;
            io_error_r <= io_error_s;
        end
    end

    // Transaction address/data latches, loaded only on an accepted strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            wstrb_r <= {STRB_W{1'b0}};
        end else begin
            if (load_addr_s) begin
                addr_r <= io_addr;
            end
            if (load_wr_s) begin
                wdata_r <= io_write_data;
                wstrb_r <= io_byte_enable;
            end
        end
    end

    // Read data register: updated only when a read completes with data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_read_data_r <= {DATA_W{1'b0}};
        end else if (capture_rdata_s) begin
            io_read_data_r <= rdata;
        end
    end

    assign awaddr       = addr_r;
    assign araddr       = addr_r;
    assign awprot       = 3'b000;
    assign arprot       = 3'b000;
    assign awvalid      = awvalid_r;
    assign wvalid       = wvalid_r;
    assign wdata        = wdata_r;
    assign wstrb        = wstrb_r;
    assign arvalid      = arvalid_r;
    assign bready       = bready_r;
    assign rready       = rready_r;
    assign io_ready     = io_ready_r;
    assign io_error     = io_error_r;
    assign io_read_data = io_read_data_r;

endmodule

// File: tb/tb_axil_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_axil_io_bridge
//
// Directed bench for axil_io_bridge. The initial block plays both the CPU and
// the AXI slave one cycle at a time. Inputs are driven, and outputs sampled,
// on the falling edge. Every issued transaction pushes its expected
// completion (error flag plus read data) onto a queue. A monitor pops an
// entry on each io_ready pulse and compares it. Cycle-specific behaviour is
// checked inline.
// Build with AXIL_IO_BRIDGE_TIMEOUT_EN defined to include the watchdog case.
// -----------------------------------------------------------------------------
module tb_axil_io_bridge;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [ADDR_W-1:0] io_addr;
    logic [3:0]        io_byte_enable;
    logic [DATA_W-1:0] io_write_data;
    logic [DATA_W-1:0] io_read_data;
    logic              io_ready, io_error;
    logic              awvalid, awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              wvalid, wready;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
    logic              bvalid, bready;
    logic [1:0]        bresp;
    logic              arvalid, arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              rvalid, rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rd;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] last_rd;
    int                total = 0;
    int                bad   = 0;

    axil_io_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_addr(io_addr),
        .io_byte_enable(io_byte_enable), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready), .io_error(io_error),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        io_addr_strobe  = 1'b1;
        io_write_strobe = 1'b1;
        io_read_strobe  = 1'b0;
        io_addr         = a;
        io_write_data   = d;
        io_byte_enable  = be;
    endtask

    task automatic start_read(input logic [31:0] a);
        io_addr_strobe  = 1'b1;
        io_write_strobe = 1'b0;
        io_read_strobe  = 1'b1;
        io_addr         = a;
    endtask

    task automatic clear_strobe();
        io_addr_strobe  = 1'b0;
        io_write_strobe = 1'b0;
        io_read_strobe  = 1'b0;
    endtask

    task automatic push_exp(input logic err, input logic [31:0] rd);
        exp_t e;
        e.err = err;
        e.rd  = rd;
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every completion must match the oldest expectation.
    always @(negedge clk) begin
        if (io_ready) begin
            total++;
            assert (sb.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_io_ready: observed=1 expected=0");
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_io_error", 64'(io_error), 64'(e.err));
                check("sb_io_read_data", 64'(io_read_data), 64'(e.rd));
            end
        end
    end

    // Hard stop in case the sequence itself stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed=hang expected=finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        rst_n = 1'b0;
        clear_strobe();
        io_addr = 32'h0; io_write_data = 32'h0; io_byte_enable = 4'h0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        last_rd = 32'h0;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_io_ready", 64'(io_ready), 64'd0);
        check("rst_io_error", 64'(io_error), 64'd0);
        check("rst_io_read_data", 64'(io_read_data), 64'd0);
        check("rst_awaddr", 64'(awaddr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_wstrb", 64'(wstrb), 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_bready", 64'(bready), 64'd1);
        check("idle_rready", 64'(rready), 64'd1);

        // ---- zero-wait write, OKAY ----
        awready = 1'b1; wready = 1'b1;
        start_write(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        push_exp(1'b0, last_rd);
        tick(); clear_strobe();                                   // cycle 1
        check("w0_awvalid_c1", 64'(awvalid), 64'd1);
        check("w0_wvalid_c1", 64'(wvalid), 64'd1);
        check("w0_awaddr", 64'(awaddr), 64'h1000);
        check("w0_wdata", 64'(wdata), 64'hDEAD_BEEF);
        check("w0_wstrb", 64'(wstrb), 64'hF);
        check("w0_awprot", 64'(awprot), 64'd0);
        check("w0_bready_write", 64'(bready), 64'd0);
        tick();                                                   // cycle 2
        check("w0_awvalid_c2", 64'(awvalid), 64'd0);
        check("w0_wvalid_c2", 64'(wvalid), 64'd0);
        check("w0_bready_c2", 64'(bready), 64'd1);
        check("w0_io_ready_c2", 64'(io_ready), 64'd0);
        bvalid = 1'b1; bresp = 2'b00;
        tick(); bvalid = 1'b0;                                    // cycle 3
        check("w0_io_ready_c3", 64'(io_ready), 64'd1);
        check("w0_io_error_c3", 64'(io_error), 64'd0);
        tick();
        check("w0_io_ready_c4", 64'(io_ready), 64'd0);

        // ---- write, awready delayed, DECERR, stray strobe ignored ----
        awready = 1'b0; wready = 1'b1;
        start_write(32'h0000_3008, 32'hA5A5_0F0F, 4'b0110);
        push_exp(1'b1, last_rd);
        tick(); clear_strobe();                                   // cycle 1
        check("w1_awvalid_c1", 64'(awvalid), 64'd1);
        check("w1_wvalid_c1", 64'(wvalid), 64'd1);
        check("w1_wstrb", 64'(wstrb), 64'b0110);
        tick();                                                   // cycle 2
        check("w1_wvalid_drop_c2", 64'(wvalid), 64'd0);
        check("w1_awvalid_c2", 64'(awvalid), 64'd1);
        start_read(32'h7777_0000);
        tick(); clear_strobe();                                   // cycle 3
        check("w1_ignored_arvalid", 64'(arvalid), 64'd0);
        check("w1_ignored_awaddr", 64'(awaddr), 64'h3008);
        check("w1_awvalid_c3", 64'(awvalid), 64'd1);
        tick();                                                   // cycle 4
        check("w1_awvalid_c4", 64'(awvalid), 64'd1);
        awready = 1'b1;
        tick();                                                   // cycle 5
        check("w1_awvalid_c5", 64'(awvalid), 64'd0);
        check("w1_bready_c5", 64'(bready), 64'd1);
        bvalid = 1'b1; bresp = 2'b11;
        tick(); bvalid = 1'b0; bresp = 2'b00;                     // cycle 6
        check("w1_io_ready_c6", 64'(io_ready), 64'd1);
        check("w1_io_error_c6", 64'(io_error), 64'd1);
        tick();
        check("w1_single_ready", 64'(io_ready), 64'd0);

        // ---- read with SLVERR, then write back-to-back ----
        arready = 1'b1;
        start_read(32'h0000_2004);
        push_exp(1'b1, 32'h1234_5678);
        last_rd = 32'h1234_5678;
        tick(); clear_strobe();                                   // cycle 1
        check("r0_arvalid_c1", 64'(arvalid), 64'd1);
        check("r0_araddr", 64'(araddr), 64'h2004);
        check("r0_arprot", 64'(arprot), 64'd0);
        check("r0_rready_c1", 64'(rready), 64'd0);
        tick();                                                   // cycle 2
        check("r0_arvalid_c2", 64'(arvalid), 64'd0);
        check("r0_rready_c2", 64'(rready), 64'd1);
        rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b10;
        tick(); rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;      // cycle 3
        check("r0_io_ready", 64'(io_ready), 64'd1);
        check("r0_io_error", 64'(io_error), 64'd1);
        check("r0_io_read_data", 64'(io_read_data), 64'h1234_5678);
        start_write(32'h0000_4000, 32'h0BAD_F00D, 4'hF);
        push_exp(1'b0, last_rd);
        tick(); clear_strobe();
        check("w2_awvalid", 64'(awvalid), 64'd1);
        tick();
        bvalid = 1'b1; bresp = 2'b00;
        tick(); bvalid = 1'b0;
        check("w2_io_ready", 64'(io_ready), 64'd1);
        check("w2_rdata_hold", 64'(io_read_data), 64'h1234_5678);

        // ---- read strobe in the same cycle as the write's io_ready ----
        start_read(32'h0000_5000);
        push_exp(1'b0, 32'hCAFE_F00D);
        last_rd = 32'hCAFE_F00D;
        tick(); clear_strobe();
        check("b2b_arvalid", 64'(arvalid), 64'd1);
        check("b2b_araddr", 64'(araddr), 64'h5000);
        tick();
        rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
        tick(); rvalid = 1'b0; rdata = 32'h0;
        check("b2b_io_ready", 64'(io_ready), 64'd1);
        check("b2b_io_error", 64'(io_error), 64'd0);
        check("b2b_io_read_data", 64'(io_read_data), 64'hCAFE_F00D);

        // ---- stray responses while idle are drained silently ----
        tick();
        bvalid = 1'b1; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        tick(); bvalid = 1'b0; rvalid = 1'b0; rdata = 32'h0;
        tick();
        check("stray_io_ready", 64'(io_ready), 64'd0);
        check("stray_rdata_hold", 64'(io_read_data), 64'hCAFE_F00D);

        // ---- reset while waiting in WRESP ----
        start_write(32'h0000_6000, 32'h1111_2222, 4'h3);
        tick(); clear_strobe();
        tick();
        check("rstw_bready", 64'(bready), 64'd1);
        rst_n = 1'b0;
        last_rd = 32'h0;
        tick(); rst_n = 1'b1;
        check("rstw_awvalid", 64'(awvalid), 64'd0);
        check("rstw_wvalid", 64'(wvalid), 64'd0);
        check("rstw_arvalid", 64'(arvalid), 64'd0);
        check("rstw_io_ready", 64'(io_ready), 64'd0);
        check("rstw_io_read_data", 64'(io_read_data), 64'd0);
        bvalid = 1'b1; bresp = 2'b00;
        tick(); bvalid = 1'b0;
        tick();
        check("rstw_late_b_no_ready", 64'(io_ready), 64'd0);
        start_read(32'h0000_8000);
        push_exp(1'b0, 32'h1357_9BDF);
        last_rd = 32'h1357_9BDF;
        tick(); clear_strobe();
        check("rstw_idle_arvalid", 64'(arvalid), 64'd1);
        tick();
        rvalid = 1'b1; rdata = 32'h1357_9BDF;
        tick(); rvalid = 1'b0; rdata = 32'h0;
        check("rstw_read_ready", 64'(io_ready), 64'd1);

`ifdef AXIL_IO_BRIDGE_TIMEOUT_EN
        // ---- watchdog: arready never comes, TIMEOUT = 8 ----
        tick();
        arready = 1'b0;
        start_read(32'h0000_9000);
        push_exp(1'b1, last_rd);
        tick(); clear_strobe();
        for (int k = 1; k <= 8; k++) begin
            check("wd_arvalid_hold", 64'(arvalid), 64'd1);
            check("wd_no_ready_yet", 64'(io_ready), 64'd0);
            tick();
        end
        check("wd_arvalid_drop", 64'(arvalid), 64'd0);
        check("wd_io_ready", 64'(io_ready), 64'd1);
        check("wd_io_error", 64'(io_error), 64'd1);
        check("wd_rdata_hold", 64'(io_read_data), 64'(last_rd));
        rvalid = 1'b1; rdata = 32'hDEAD_0000;
        tick(); rvalid = 1'b0; rdata = 32'h0;
        tick();
        check("wd_stray_no_ready", 64'(io_ready), 64'd0);
        check("wd_stray_rdata_hold", 64'(io_read_data), 64'(last_rd));
        arready = 1'b1;
`endif

        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
